// File: rtl/seven_segment_ctrl.sv
// Avalon-MM controller for NUM_DIGITS seven-segment digits: hex/raw patterns, enable, blink, PWM dimming.
// Define SEVEN_SEGMENT_PWM_EN to build the PWM counter and writable BRIGHT register.
module seven_segment_ctrl #(
    parameter int NUM_DIGITS = 6,
    parameter int BLINK_DIV  = 25000000,
    parameter int BRIGHT_W   = 4,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [3:0]              avs_address,
    input  logic                    avs_write,
    input  logic [31:0]             avs_writedata,
    input  logic                    avs_read,
    output logic [31:0]             avs_readdata,
    output logic [7*NUM_DIGITS-1:0] coe_seg,
    output logic                    coe_blink_phase
);

    localparam int                    BC_W       = $clog2(BLINK_DIV);
    localparam logic [BC_W-1:0]       BLINK_LAST = BC_W'(BLINK_DIV - 1);
    localparam logic [BRIGHT_W-1:0]   BRIGHT_MAX = '1;
    localparam logic [7*NUM_DIGITS-1:0] SEG_DARK = (ACTIVE_LOW != 0) ? '1 : '0;

    logic [4*NUM_DIGITS-1:0] data_reg;
    logic [NUM_DIGITS-1:0]   enable_reg;
    logic [NUM_DIGITS-1:0]   blink_reg;
    logic [NUM_DIGITS-1:0]   mode_reg;
    logic [6:0]              raw_reg [NUM_DIGITS];
    logic [BRIGHT_W-1:0]     bright_val;
    logic                    pwm_on;

    logic [BC_W-1:0]         blink_cnt_reg;
    logic                    phase_reg;
    logic [31:0]             readdata_reg;
    logic [31:0]             rd_next;
    logic [7*NUM_DIGITS-1:0] seg_reg;
    logic [7*NUM_DIGITS-1:0] seg_next;

    logic unused_wd;
    assign unused_wd = ^avs_writedata;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'h3F;
            4'h1: hex7 = 7'h06;
            4'h2: hex7 = 7'h5B;
            4'h3: hex7 = 7'h4F;
            4'h4: hex7 = 7'h66;
            4'h5: hex7 = 7'h6D;
            4'h6: hex7 = 7'h7D;
            4'h7: hex7 = 7'h07;
            4'h8: hex7 = 7'h7F;
            4'h9: hex7 = 7'h6F;
            4'hA: hex7 = 7'h77;
            4'hB: hex7 = 7'h7C;
            4'hC: hex7 = 7'h39;
            4'hD: hex7 = 7'h5E;
            4'hE: hex7 = 7'h79;
            default: hex7 = 7'h71;
        endcase
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_reg   <= '0;
            enable_reg <= '0;
            blink_reg  <= '0;
            mode_reg   <= '0;
            for (int i = 0; i < NUM_DIGITS; i++) raw_reg[i] <= '0;
        end else if (avs_write) begin
            case (avs_address)
                4'h0: data_reg   <= avs_writedata[4*NUM_DIGITS-1:0];
                4'h1: enable_reg <= avs_writedata[NUM_DIGITS-1:0];
                4'h2: blink_reg  <= avs_writedata[NUM_DIGITS-1:0];
                4'h4: mode_reg   <= avs_writedata[NUM_DIGITS-1:0];
                default: begin
                    for (int i = 0; i < NUM_DIGITS; i++)
                        if (avs_address == 4'(8 + i)) raw_reg[i] <= avs_writedata[6:0];
                end
            endcase
        end
    end

`ifdef SEVEN_SEGMENT_PWM_EN
    logic [BRIGHT_W-1:0] bright_reg;
    logic [BRIGHT_W-1:0] pc_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bright_reg <= BRIGHT_MAX;
            pc_reg     <= '0;
        end else begin
            pc_reg <= pc_reg + 1'b1;
            if (avs_write && avs_address == 4'h3)
                bright_reg <= avs_writedata[BRIGHT_W-1:0];
        end
    end

    assign bright_val = bright_reg;
    // Max duty is forced fully on; otherwise pc never exceeds max and one slot stays dark.
    assign pwm_on     = (pc_reg < bright_reg) || (bright_reg == BRIGHT_MAX);
`else
    assign bright_val = BRIGHT_MAX;
    assign pwm_on     = 1'b1;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            blink_cnt_reg <= '0;
            phase_reg     <= 1'b0;
        end else if (blink_cnt_reg == BLINK_LAST) begin
            blink_cnt_reg <= '0;
            phase_reg     <= ~phase_reg;
        end else begin
            blink_cnt_reg <= blink_cnt_reg + 1'b1;
        end
    end

    always_comb begin
        rd_next = '0;
        case (avs_address)
            4'h0: rd_next[4*NUM_DIGITS-1:0] = data_reg;
            4'h1: rd_next[NUM_DIGITS-1:0]   = enable_reg;
            4'h2: rd_next[NUM_DIGITS-1:0]   = blink_reg;
            4'h3: rd_next[BRIGHT_W-1:0]     = bright_val;
            4'h4: rd_next[NUM_DIGITS-1:0]   = mode_reg;
            default: begin
                for (int i = 0; i < NUM_DIGITS; i++)
                    if (avs_address == 4'(8 + i)) rd_next[6:0] = raw_reg[i];
            end
        endcase
    end

    // Registers above are sampled before this edge's write, so a same-cycle read sees the old value.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)      readdata_reg <= '0;
        else if (avs_read) readdata_reg <= rd_next;
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            logic [6:0] pat;
            logic       lit;
            assign pat = mode_reg[gi] ? raw_reg[gi] : hex7(data_reg[4*gi +: 4]);
            assign lit = enable_reg[gi] && !(blink_reg[gi] && phase_reg) && pwm_on;
            if (ACTIVE_LOW != 0) begin : g_low
                assign seg_next[7*gi +: 7] = lit ? ~pat : 7'h7F;
            end else begin : g_high
                assign seg_next[7*gi +: 7] = lit ? pat : 7'h00;
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) seg_reg <= SEG_DARK;
        else          seg_reg <= seg_next;
    end

    assign avs_readdata    = readdata_reg;
    assign coe_seg         = seg_reg;
    assign coe_blink_phase = phase_reg;

endmodule

// File: tb/tb_seven_segment_ctrl.sv
// Directed self-checking bench for seven_segment_ctrl (6 digits, BLINK_DIV=4, BRIGHT_W=2, active-low).
module tb_seven_segment_ctrl;

`ifdef SEVEN_SEGMENT_PWM_EN
    localparam bit PWM = 1'b1;
`else
    localparam bit PWM = 1'b0;
`endif

    logic        clk;
    logic        reset_n;
    logic [3:0]  avs_address;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic        avs_read;
    logic [31:0] avs_readdata;
    logic [41:0] coe_seg;
    logic        coe_blink_phase;

    int n_tests = 0;
    int n_fail  = 0;

    seven_segment_ctrl #(
        .NUM_DIGITS(6),
        .BLINK_DIV (4),
        .BRIGHT_W  (2),
        .ACTIVE_LOW(1)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .avs_address    (avs_address),
        .avs_write      (avs_write),
        .avs_writedata  (avs_writedata),
        .avs_read       (avs_read),
        .avs_readdata   (avs_readdata),
        .coe_seg        (coe_seg),
        .coe_blink_phase(coe_blink_phase)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] dig(input int i);
        dig = coe_seg[7*i +: 7];
    endfunction

    task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        avs_address = a; avs_writedata = d; avs_write = 1'b1;
        @(negedge clk);
        avs_write = 1'b0;
        $display("[TB] write addr=%0h data=%08h", a, d);
    endtask

    task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
        @(negedge clk);
        avs_address = a; avs_read = 1'b1;
        @(negedge clk);
        avs_read = 1'b0;
        d = avs_readdata;
        $display("[TB] read  addr=%0h data=%08h", a, d);
    endtask

    task automatic read_check(input string tag, input logic [3:0] a, input logic [31:0] exp);
        logic [31:0] d;
        bus_read(a, d);
        check(tag, 64'(d), 64'(exp));
    endtask

    // Count samples over 8 cycles where digit 2 (hex 8, all segments) is lit.
    task automatic count_lit(output int lit);
        lit = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (dig(2) == 7'h00) lit++;
        end
    endtask

    initial begin
        logic [31:0] d;
        int          lit;
        bit          ph0, exp_ph, d_ph, seen;
        reset_n = 1'b1; avs_address = '0; avs_write = 1'b0; avs_writedata = '0; avs_read = 1'b0;
        #1 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_seg", 64'(coe_seg), 64'h3FF_FFFF_FFFF);
        check("reset_readdata", 64'(avs_readdata), 64'h0);
        check("reset_phase", 64'(coe_blink_phase), 64'h0);
        reset_n = 1'b1;
        read_check("reset_bright", 4'h3, 32'h3);

        // Hex decode
        bus_write(4'h0, 32'h00A810);
        bus_write(4'h1, 32'h3F);
        check("enable_latency_d0", 64'(dig(0)), 64'h7F);
        @(negedge clk);
        check("hex_d0", 64'(dig(0)), 64'h40);
        check("hex_d1", 64'(dig(1)), 64'h79);
        check("hex_d2", 64'(dig(2)), 64'h00);
        check("hex_d3", 64'(dig(3)), 64'h08);
        check("hex_d5", 64'(dig(5)), 64'h40);

        // Raw mode and enable
        bus_write(4'h4, 32'h01);
        bus_write(4'h8, 32'h49);
        @(negedge clk);
        check("raw_d0", 64'(dig(0)), 64'h36);
        bus_write(4'h1, 32'h3E);
        @(negedge clk);
        check("disable_d0", 64'(dig(0)), 64'h7F);
        check("disable_d1_kept", 64'(dig(1)), 64'h79);
        read_check("rd_raw0", 4'h8, 32'h49);
        read_check("rd_enable", 4'h1, 32'h3E);

        // Same-cycle read and write returns old value, then readdata holds
        @(negedge clk);
        avs_address = 4'h4; avs_writedata = 32'h0; avs_write = 1'b1; avs_read = 1'b1;
        @(negedge clk);
        avs_write = 1'b0; avs_read = 1'b0;
        $display("[TB] rd+wr addr=4 data=%08h", avs_readdata);
        check("rw_same_old", 64'(avs_readdata), 64'h1);
        @(negedge clk);
        check("readdata_hold", 64'(avs_readdata), 64'h1);
        read_check("rw_same_new", 4'h4, 32'h0);
        bus_write(4'h4, 32'h01);

        // Blink: digit1 follows the phase one cycle late
        bus_write(4'h2, 32'h02);
        seen = 1'b0;
        ph0  = coe_blink_phase;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            if (coe_blink_phase != ph0) seen = 1'b1;
        end
        check("blink_toggle_seen", 64'(seen), 64'h1);
        ph0 = coe_blink_phase;
        for (int k = 0; k < 16; k++) begin
            if (k > 0) @(negedge clk);
            exp_ph = ph0 ^ 1'((k / 4) % 2);
            d_ph   = (k == 0) ? ~ph0 : (ph0 ^ 1'(((k - 1) / 4) % 2));
            $display("[TB] blink k=%0d phase=%0b d1=%02h", k, coe_blink_phase, dig(1));
            check("blink_phase", 64'(coe_blink_phase), 64'(exp_ph));
            check("blink_d1", 64'(dig(1)), d_ph ? 64'h7F : 64'h79);
            check("blink_d2_steady", 64'(dig(2)), 64'h00);
        end
        bus_write(4'h2, 32'h00);

        // PWM dimming
        bus_write(4'h3, 32'h1);
        @(negedge clk);
        count_lit(lit);
        $display("[TB] bright=1 lit=%0d/8", lit);
        check("pwm_bright1", 64'(lit), PWM ? 64'd2 : 64'd8);
        read_check("rd_bright1", 4'h3, PWM ? 32'h1 : 32'h3);
        bus_write(4'h3, 32'h0);
        @(negedge clk);
        count_lit(lit);
        $display("[TB] bright=0 lit=%0d/8", lit);
        check("pwm_bright0", 64'(lit), PWM ? 64'd0 : 64'd8);
        bus_write(4'h3, 32'h3);
        @(negedge clk);
        count_lit(lit);
        $display("[TB] bright=3 lit=%0d/8", lit);
        check("pwm_bright3", 64'(lit), 64'd8);

        // Unmapped addresses and register width
        read_check("rd_addr5", 4'h5, 32'h0);
        read_check("rd_addrF", 4'hF, 32'h0);
        bus_write(4'h0, 32'hFFFF_FFFF);
        read_check("rd_data_width", 4'h0, 32'h00FF_FFFF);

        // Asynchronous reset mid-blink
        bus_write(4'h2, 32'h02);
        repeat (5) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        $display("[TB] async reset seg=%011h rd=%08h phase=%0b", coe_seg, avs_readdata, coe_blink_phase);
        check("async_seg", 64'(coe_seg), 64'h3FF_FFFF_FFFF);
        check("async_readdata", 64'(avs_readdata), 64'h0);
        check("async_phase", 64'(coe_blink_phase), 64'h0);
        @(negedge clk);
        reset_n = 1'b1;
        read_check("post_data", 4'h0, 32'h0);
        read_check("post_enable", 4'h1, 32'h0);
        read_check("post_blink", 4'h2, 32'h0);
        read_check("post_bright", 4'h3, 32'h3);
        read_check("post_mode", 4'h4, 32'h0);
        read_check("post_raw0", 4'h8, 32'h0);
        check("post_seg", 64'(coe_seg), 64'h3FF_FFFF_FFFF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
